// File: rtl/accum_dump_serializer.sv
// N-channel accumulate-and-dump decimator with a double-buffered snapshot and strobed frame serializer.
// Optional build macro: SATURATE_EN (clamp sums at all-ones and raise sticky per-channel sat flags).
module accum_dump_serializer #(
   parameter int unsigned N_CH      = 2,
   parameter int unsigned IN_WIDTH  = 1,
   parameter int unsigned ACC_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH*IN_WIDTH-1:0] din,
   input  logic                     din_valid,
   input  logic [ACC_WIDTH-1:0]     ds_ratio,
   input  logic                     ser_en,
   input  logic                     overrun_clr,
   output logic                     ser_start,
   output logic                     ser_out,
   output logic                     ser_busy,
   output logic                     overrun,
   output logic [N_CH-1:0]          sat
);

   localparam int unsigned FRAME_W  = N_CH * ACC_WIDTH;
   localparam int unsigned BITCNT_W = $clog2(FRAME_W + 1);

   typedef enum logic [1:0] {IDLE, START, SHIFT} stateT;

   stateT                 stateQ, stateD;
   logic [ACC_WIDTH-1:0]  acc      [N_CH];
   logic [ACC_WIDTH-1:0]  snapshot [N_CH];
   logic [ACC_WIDTH-1:0]  sumNext  [N_CH];
   logic [ACC_WIDTH-1:0]  count, ratioQ, effRatio, lastIdx;
   logic                  ratioLoaded, pending, dump, load, lastBit;
   logic [FRAME_W-1:0]    frame, shiftQ, shiftD;
   logic [BITCNT_W-1:0]   bitCnt, bitCntD;
   logic                  serOutD, serStartD, serBusyD;

   // Window length: until the first post-reset edge latches ratioQ, use the live input.
   always_comb begin
      effRatio = ratioLoaded ? ratioQ : ds_ratio;
      lastIdx  = (effRatio == '0) ? '0 : effRatio - ACC_WIDTH'(1);
      dump     = din_valid && (count == lastIdx);
   end

`ifdef SATURATE_EN
   localparam int unsigned SUM_W = ACC_WIDTH + 1;
   logic [SUM_W-1:0] sumWide [N_CH];
   logic [N_CH-1:0]  sumOvf;

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         sumWide[k] = {1'b0, acc[k]} + SUM_W'(din[k*IN_WIDTH +: IN_WIDTH]);
         sumOvf[k]  = sumWide[k][ACC_WIDTH];
         sumNext[k] = sumOvf[k] ? '1 : sumWide[k][ACC_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sat <= '0;
      else if (din_valid) sat <= sat | sumOvf;
   end
`else
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         sumNext[k] = acc[k] + ACC_WIDTH'(din[k*IN_WIDTH +: IN_WIDTH]);
      end
   end

   assign sat = '0;
`endif

   // Accumulate, count and dump; the dump sample is folded into the snapshot so nothing is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count       <= '0;
         ratioQ      <= '0;
         ratioLoaded <= 1'b0;
         for (int k = 0; k < N_CH; k++) begin
            acc[k]      <= '0;
            snapshot[k] <= '0;
         end
      end else begin
         ratioLoaded <= 1'b1;
         if (dump || !ratioLoaded) ratioQ <= ds_ratio;
         if (din_valid) begin
            if (dump) begin
               count <= '0;
               for (int k = 0; k < N_CH; k++) begin
                  acc[k]      <= '0;
                  snapshot[k] <= sumNext[k];
               end
            end else begin
               count <= count + ACC_WIDTH'(1);
               for (int k = 0; k < N_CH; k++) acc[k] <= sumNext[k];
            end
         end
      end
   end

   // A load in the dump cycle consumes the old snapshot, so only an unconsumed overwrite is an overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (dump)      pending <= 1'b1;
         else if (load) pending <= 1'b0;
         if (dump && pending && !load) overrun <= 1'b1;
         else if (overrun_clr)         overrun <= 1'b0;
      end
   end

   // Channel 0 occupies the frame MSBs so it leaves first, each channel MSB first.
   always_comb begin
      frame = '0;
      for (int k = 0; k < N_CH; k++) begin
         frame[FRAME_W-1-k*ACC_WIDTH -: ACC_WIDTH] = snapshot[k];
      end
   end

   assign lastBit = (bitCnt == BITCNT_W'(FRAME_W));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stateQ <= IDLE;
      else       stateQ <= stateD;
   end

   always_comb begin
      stateD = stateQ;
      if (ser_en) begin
         case (stateQ)
            IDLE:    if (pending) stateD = START;
            START:   if (!lastBit) stateD = SHIFT;
                     else          stateD = pending ? START : IDLE;
            SHIFT:   if (lastBit)  stateD = pending ? START : IDLE;
            default: stateD = IDLE;
         endcase
      end
   end

   // Next values of the serializer datapath; everything holds between ser_en strobes.
   always_comb begin
      load      = 1'b0;
      shiftD    = shiftQ;
      bitCntD   = bitCnt;
      serOutD   = ser_out;
      serStartD = ser_start;
      serBusyD  = ser_busy;
      if (ser_en) begin
         case (stateQ)
            IDLE: load = pending;
            START, SHIFT: begin
               serStartD = 1'b0;
               if (lastBit) begin
                  load     = pending;
                  serOutD  = 1'b0;
                  serBusyD = 1'b0;
               end else begin
                  serOutD = shiftQ[FRAME_W-1];
                  shiftD  = shiftQ << 1;
                  bitCntD = bitCnt + BITCNT_W'(1);
               end
            end
            default: ;
         endcase
         if (load) begin
            serOutD   = frame[FRAME_W-1];
            shiftD    = frame << 1;
            bitCntD   = BITCNT_W'(1);
            serStartD = 1'b1;
            serBusyD  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shiftQ    <= '0;
         bitCnt    <= '0;
         ser_out   <= 1'b0;
         ser_start <= 1'b0;
         ser_busy  <= 1'b0;
      end else begin
         shiftQ    <= shiftD;
         bitCnt    <= bitCntD;
         ser_out   <= serOutD;
         ser_start <= serStartD;
         ser_busy  <= serBusyD;
      end
   end

endmodule

// File: tb/tb_accum_dump_serializer.sv
// Scoreboard bench for accum_dump_serializer: a window/slot reference model predicts frames and flags,
// a monitor reassembles serial frames and compares them against the expected-frame queue.
module tb_accum_dump_serializer;
   localparam int unsigned N_CH      = 2;
   localparam int unsigned IN_WIDTH  = 4;
   localparam int unsigned ACC_WIDTH = 8;
   localparam int unsigned DW        = N_CH * IN_WIDTH;
   localparam int unsigned FRAME_W   = N_CH * ACC_WIDTH;
   localparam int          ACC_MAX   = (1 << ACC_WIDTH) - 1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [DW-1:0]        din = '0;
   logic                 din_valid = 1'b0;
   logic [ACC_WIDTH-1:0] ds_ratio = '0;
   logic                 ser_en = 1'b0;
   logic                 overrun_clr = 1'b0;
   logic                 ser_start, ser_out, ser_busy, overrun;
   logic [N_CH-1:0]      sat;

   accum_dump_serializer #(.N_CH(N_CH), .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .ds_ratio(ds_ratio),
      .ser_en(ser_en), .overrun_clr(overrun_clr), .ser_start(ser_start), .ser_out(ser_out),
      .ser_busy(ser_busy), .overrun(overrun), .sat(sat)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [FRAME_W-1:0] expQ[$];

   // Reference model: sums per window, one pending slot, bit periods left in the frame on the wire.
   int              mSum[N_CH];
   int              mCnt, mWin, mTx;
   logic [FRAME_W-1:0] mSnap;
   bit              mPend, mOv, mStart;
   bit [N_CH-1:0]   mSat;

   logic [FRAME_W-1:0] lastFrame;
   logic [FRAME_W-1:0] rxBits;
   int  rxCnt = 0;
   bit  collecting = 0;
   bit  countOn = 0;
   int  startCnt, busyCnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int effRatio(input logic [ACC_WIDTH-1:0] r);
      return (r == 0) ? 1 : int'(r);
   endfunction

   task automatic modelReset();
      for (int k = 0; k < N_CH; k++) mSum[k] = 0;
      mCnt = 0; mWin = 0; mTx = 0; mSnap = '0;
      mPend = 0; mOv = 0; mStart = 0; mSat = '0;
   endtask

   task automatic modelEdge(input logic [DW-1:0] d, input logic v, input logic [ACC_WIDTH-1:0] r,
                            input logic en, input logic clr);
      bit loadNow, dumpNow;
      logic [FRAME_W-1:0] newSnap;
      int dk;
      loadNow = 0; dumpNow = 0; newSnap = '0;
      if (mWin == 0) mWin = effRatio(r);
      if (en) begin
         if (mTx > 0) mTx--;
         if (mTx == 0 && mPend) begin
            loadNow = 1;
            expQ.push_back(mSnap);
            mTx = FRAME_W;
         end
         mStart = loadNow;
      end
      if (v) begin
         for (int k = 0; k < N_CH; k++) begin
            dk = int'(d[k*IN_WIDTH +: IN_WIDTH]);
`ifdef SATURATE_EN
            if (mSum[k] + dk > ACC_MAX) begin mSum[k] = ACC_MAX; mSat[k] = 1'b1; end
            else mSum[k] = mSum[k] + dk;
`else
            mSum[k] = (mSum[k] + dk) % (ACC_MAX + 1);
`endif
         end
         mCnt++;
         if (mCnt == mWin) begin
            dumpNow = 1;
            for (int k = 0; k < N_CH; k++) begin
               newSnap[FRAME_W-1-k*ACC_WIDTH -: ACC_WIDTH] = ACC_WIDTH'(mSum[k]);
               mSum[k] = 0;
            end
            mCnt = 0;
            mWin = effRatio(r);
         end
      end
      if (dumpNow && mPend && !loadNow) mOv = 1;
      else if (clr) mOv = 0;
      if (loadNow) mPend = 0;
      if (dumpNow) begin mSnap = newSnap; mPend = 1; end
   endtask

   // Called at a negedge; drives one cycle, advances the model and checks the flags after the edge.
   task automatic step(input logic [DW-1:0] d, input logic v, input logic [ACC_WIDTH-1:0] r,
                       input logic en, input logic clr);
      din = d; din_valid = v; ds_ratio = r; ser_en = en; overrun_clr = clr;
      @(posedge clk);
      modelEdge(d, v, r, en, clr);
      #1;
      check("ser_busy", 32'(ser_busy), 32'(mTx > 0));
      check("ser_start", 32'(ser_start), 32'(mStart));
      check("overrun", 32'(overrun), 32'(mOv));
      check("sat", 32'(sat), 32'(mSat));
      if (mTx == 0) check("ser_out_idle", 32'(ser_out), 32'd0);
      if (countOn) begin
         startCnt += int'(ser_start);
         busyCnt  += int'(ser_busy);
      end
      @(negedge clk);
   endtask

   task automatic applyReset();
      reset = 1'b1; din_valid = 1'b0; ser_en = 1'b0; overrun_clr = 1'b0;
      #1;
      check("rst_ser_out", 32'(ser_out), 32'd0);
      check("rst_ser_start", 32'(ser_start), 32'd0);
      check("rst_ser_busy", 32'(ser_busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);
      modelReset();
      expQ.delete();
      lastFrame = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [DW-1:0] pack2(input int c0, input int c1);
      logic [DW-1:0] d;
      d = '0;
      d[0 +: IN_WIDTH]        = IN_WIDTH'(c0);
      d[IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(c1);
      return d;
   endfunction

   function automatic logic [DW-1:0] randDin();
      logic [DW-1:0] d;
      for (int k = 0; k < N_CH; k++) d[k*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom);
      return d;
   endfunction

   // Monitor: one bit per ser_en edge, a frame starts on ser_start and is compared once complete.
   always @(posedge clk) begin
      logic enS;
      enS = ser_en;
      #1;
      if (reset) begin
         collecting = 0;
         rxCnt = 0;
      end else if (enS && ser_start) begin
         rxBits = FRAME_W'(ser_out);
         rxCnt = 1;
         collecting = 1;
      end else if (enS && collecting) begin
         rxBits = {rxBits[FRAME_W-2:0], ser_out};
         rxCnt++;
      end
      if (collecting && rxCnt == FRAME_W) begin
         collecting = 0;
         lastFrame = rxBits;
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame: got 0x%0h expected none queued at %0t", rxBits, $time);
         end else begin
            check("frame", 32'(rxBits), 32'(expQ.pop_front()));
         end
      end
   end

   initial begin
      logic [ACC_WIDTH-1:0] r;
      bit fastEn;
      modelReset();
      @(negedge clk);
      applyReset();

      // Single frame: ch0 all ones, ch1 alternating, window 4, ser_en always high.
      countOn = 1; startCnt = 0; busyCnt = 0;
      for (int i = 0; i < 4; i++) step(pack2(1, (i % 2 == 0) ? 1 : 0), 1'b1, 8'd4, 1'b1, 1'b0);
      for (int i = 0; i < 24; i++) step('0, 1'b0, 8'd4, 1'b1, 1'b0);
      countOn = 0;
      check("frame1_value", 32'(lastFrame), 32'h0402);
      check("frame1_start_cycles", 32'(startCnt), 32'd1);
      check("frame1_busy_cycles", 32'(busyCnt), 32'(FRAME_W));

      // Window 3 with valid on every other cycle: accumulators hold across gaps.
      applyReset();
      for (int i = 0; i < 40; i++) step(randDin(), 1'(i % 2), 8'd3, 1'b1, 1'b0);

      // Full-scale samples over a 20-sample window wrap modulo 2^ACC_WIDTH.
      applyReset();
      for (int i = 0; i < 20; i++) step(pack2(15, 15), 1'b1, 8'd20, 1'b1, 1'b0);
      for (int i = 0; i < 24; i++) step('0, 1'b0, 8'd20, 1'b1, 1'b0);
`ifdef SATURATE_EN
      check("wrap_frame", 32'(lastFrame), 32'hFFFF);
`else
      check("wrap_frame", 32'(lastFrame), 32'h2C2C);
`endif

      // Ratio 0 dumps every sample; a slow strobe forces overruns, then overrun_clr clears the flag.
      applyReset();
      for (int i = 0; i < 40; i++) step(randDin(), 1'b1, 8'd0, 1'(i % 8 == 7), 1'b0);
      check("overrun_set", 32'(overrun), 32'd1);
      step('0, 1'b0, 8'd0, 1'b0, 1'b1);
      check("overrun_cleared", 32'(overrun), 32'd0);

      // Ratio change mid-window only takes effect on the following window.
      applyReset();
      for (int i = 0; i < 40; i++) step(randDin(), 1'b1, (i < 2) ? 8'd4 : 8'd8, 1'b1, 1'b0);

      // Reset in the middle of a frame aborts it.
      applyReset();
      for (int i = 0; i < 4; i++) step(randDin(), 1'b1, 8'd4, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step('0, 1'b0, 8'd4, 1'b1, 1'b0);
      check("mid_frame_busy", 32'(ser_busy), 32'd1);
      applyReset();
      for (int i = 0; i < 30; i++) step(randDin(), 1'b1, 8'd5, 1'b1, 1'b0);

      // Random traffic: random windows, gaps, strobe rates and clears.
      r = 8'd6; fastEn = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) r = ACC_WIDTH'($urandom_range(0, 24));
         if ($urandom_range(0, 99) == 0) fastEn = ~fastEn;
         step(randDin(), 1'($urandom_range(0, 3) != 0), r,
              fastEn ? 1'($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 29) == 0));
      end

      // Drain outstanding frames with a bounded wait.
      begin
         int guard;
         guard = 0;
         while ((mTx != 0 || mPend) && guard < 200) begin
            step('0, 1'b0, r, 1'b1, 1'b0);
            guard++;
         end
         check("drain_done", 32'(mTx != 0 || mPend), 32'd0);
      end
      step('0, 1'b0, r, 1'b1, 1'b0);
      check("queue_empty", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
